// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// The state encoding records which requester owns the in-flight response.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_t;

    localparam logic [2:0] FUNC3_WORD = 3'b010;
    localparam int         CNT_W      = 4;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive conflicts lost by the fetch path and raises force_fetch
// once the count reaches STARVE_LIMIT, so fetch takes the next conflict slot.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic if_gnt,
    input  logic d_gnt,
    output logic force_fetch
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Next count: clear when fetch is served or gives up, saturate at the limit.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (if_gnt || !if_req) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (d_gnt) begin
            cnt_nxt_s = (cnt_r >= LIMIT) ? LIMIT : (cnt_r + CNT_W'(1));
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign force_fetch = (cnt_r == LIMIT);

endmodule : mem_arb_starve_ctr

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// load/store traffic with req/gnt/rvalid handshakes; data wins unless fetch is starving.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_func3,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wd,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_rd
);

    logic       force_fetch_s;
    logic       if_gnt_s;
    logic       d_gnt_s;
    arb_state_t state_r;
    arb_state_t state_nxt_s;
    logic       d_wen_r;

    mem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_gnt     (if_gnt_s),
        .d_gnt      (d_gnt_s),
        .force_fetch(force_fetch_s)
    );

    // Grant selection: one grant per cycle, data first unless fetch is starving.
    always_comb begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
        if (!rst_n) begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end else if (d_req && !(if_req && force_fetch_s)) begin
            d_gnt_s = 1'b1;
        end else if (if_req) begin
            if_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end
    end

    // Memory command mux driven by whichever requester holds the grant.
    always_comb begin
        mem_addr  = {ADDR_W{1'b0}};
        mem_wen   = 1'b0;
        mem_wd    = {DATA_W{1'b0}};
        mem_func3 = FUNC3_WORD;
        if (d_gnt_s) begin
            mem_addr  = d_addr;
            mem_wen   = d_wen;
            mem_wd    = d_wdata;
            mem_func3 = d_func3;
        end else if (if_gnt_s) begin
            mem_addr  = if_addr;
            mem_func3 = FUNC3_WORD;
        end else begin
            mem_addr  = {ADDR_W{1'b0}};
            mem_func3 = FUNC3_WORD;
        end
    end

    // Next owner of the response slot; every state uses the same grant rule.
    always_comb begin
        state_nxt_s = ARB_IDLE;
        case (state_r)
            ARB_IDLE, ARB_FETCH, ARB_DATA: begin
                if (if_gnt_s) begin
                    state_nxt_s = ARB_FETCH;
                end else if (d_gnt_s) begin
                    state_nxt_s = ARB_DATA;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            default: state_nxt_s = ARB_IDLE;
        endcase
    end

    // Response-owner state and the load/store flag captured at grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
            d_wen_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (d_gnt_s) begin
                d_wen_r <= d_wen;
            end else begin
                d_wen_r <= d_wen_r;
            end
        end
    end

    assign if_gnt    = if_gnt_s;
    assign d_gnt     = d_gnt_s;
    assign if_rvalid = (state_r == ARB_FETCH);
    assign d_rvalid  = (state_r == ARB_DATA);
    assign if_rdata  = (state_r == ARB_FETCH) ? mem_rd : {DATA_W{1'b0}};
    // A store acknowledgement carries zero rather than whatever the memory returned.
    assign d_rdata   = ((state_r == ARB_DATA) && !d_wen_r) ? mem_rd : {DATA_W{1'b0}};

endmodule : mem_port_arbiter
